// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions, next-PC select and
// controller state encodings. Also used by the hazard unit.
package isa_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ADD_R = 5'h01;
  localparam logic [4:0] OP_ADDI  = 5'h02;
  localparam logic [4:0] OP_JMP   = 5'h10;
  localparam logic [4:0] OP_JR    = 5'h11;
  localparam logic [4:0] OP_BEQ   = 5'h12;
  localparam logic [4:0] OP_BNE   = 5'h13;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 27;
  localparam int R_ALU_MSB = 26;
  localparam int R_ALU_LSB = 24;
  localparam int R_RD_MSB  = 23;
  localparam int R_RD_LSB  = 19;
  localparam int R_RS1_MSB = 18;
  localparam int R_RS1_LSB = 14;
  localparam int R_RS2_MSB = 13;
  localparam int R_RS2_LSB = 9;
  localparam int I_RD_MSB  = 26;
  localparam int I_RD_LSB  = 22;
  localparam int I_RS1_MSB = 21;
  localparam int I_RS1_LSB = 17;
  localparam int I_IMM_MSB = 15;
  localparam int I_IMM_LSB = 0;
  localparam int J_ADR_MSB = 26;
  localparam int J_ADR_LSB = 0;

  typedef enum logic [1:0] {
    SEL_PC4  = 2'b00,
    SEL_ADDR = 2'b01,
    SEL_RS   = 2'b10,
    SEL_BR   = 2'b11
  } next_sel_t;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } fsm_state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op == OP_NOP) || (op == OP_ADD_R) || (op == OP_ADDI) || (op == OP_JMP) ||
           (op == OP_JR) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field split, immediate sign extension and format
// classification. Kept free of state so the hazard unit can reuse it.
module instr_field_decode
  import isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  op,
  output logic [2:0]  alu,
  output logic [4:0]  rd,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [31:0] imm_sext,
  output logic [31:0] jaddr,
  output logic        is_rtype,
  output logic        is_branch,
  output logic        writes_rd,
  output logic        is_legal
);

  assign op        = instr[OP_MSB:OP_LSB];
  assign alu       = instr[R_ALU_MSB:R_ALU_LSB];
  assign is_rtype  = (op == OP_ADD_R);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign writes_rd = (op == OP_ADD_R) || (op == OP_ADDI);
  assign is_legal  = op_is_legal(op);

  assign rd       = is_rtype ? instr[R_RD_MSB:R_RD_LSB] : instr[I_RD_MSB:I_RD_LSB];
  assign rs1_addr = is_rtype ? instr[R_RS1_MSB:R_RS1_LSB] : instr[I_RS1_MSB:I_RS1_LSB];
  // Branches compare rs1 against the register named in the rd slot.
  assign rs2_addr = is_branch ? instr[I_RD_MSB:I_RD_LSB] : instr[R_RS2_MSB:R_RS2_LSB];

  assign imm_sext = {{16{instr[I_IMM_MSB]}}, instr[I_IMM_MSB:I_IMM_LSB]};
  assign jaddr    = {5'b0, instr[J_ADR_MSB:J_ADR_LSB]};

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch consumer: decodes the fetched word, steers the next-PC mux, squashes the
// wrong-path word after a redirect and registers decoded fields for execute.
//
// state | meaning
// BOOT  | fetch register holds a bubble after reset; nothing issued
// RUN   | decode and issue the word at cur_pc; redirect if jump/taken branch
// FLUSH | word in fetch register is wrong-path; squash it, cur_pc holds
module fetch_redirect_ctrl
  import isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Instruction,
  input  logic [W-1:0] rs1_data,
  input  logic [W-1:0] rs2_data,
  output logic [4:0]   rs1_addr,
  output logic [4:0]   rs2_addr,
  output logic [1:0]   NextInstrSel,
  output logic [W-1:0] address,
  output logic [W-1:0] Rs,
  output logic [W-1:0] Branch,
  output logic         ex_valid,
  output logic [4:0]   ex_opcode,
  output logic [2:0]   ex_aluop,
  output logic [4:0]   ex_rd,
  output logic [W-1:0] ex_a,
  output logic [W-1:0] ex_b,
  output logic [W-1:0] ex_imm,
  output logic [W-1:0] ex_pc,
  output logic         ex_illegal
);

  fsm_state_t  state;
  logic [31:0] cur_pc;
  logic [31:0] next_pc;
  next_sel_t   sel;

  logic [4:0]  d_op;
  logic [2:0]  d_alu;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic [31:0] d_jaddr;
  logic        d_rtype, d_branch, d_writes, d_legal;

  instr_field_decode u_dec (
    .instr     (Instruction),
    .op        (d_op),
    .alu       (d_alu),
    .rd        (d_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .imm_sext  (d_imm),
    .jaddr     (d_jaddr),
    .is_rtype  (d_rtype),
    .is_branch (d_branch),
    .writes_rd (d_writes),
    .is_legal  (d_legal)
  );

  assign address = d_jaddr;
  assign Rs      = rs1_data;
  assign Branch  = cur_pc + 32'd4 + {d_imm[29:0], 2'b00};

  always_comb begin
    sel = SEL_PC4;
    if (state == RUN) begin
      case (d_op)
        OP_JMP:  sel = SEL_ADDR;
        OP_JR:   sel = SEL_RS;
        OP_BEQ:  sel = (rs1_data == rs2_data) ? SEL_BR : SEL_PC4;
        OP_BNE:  sel = (rs1_data != rs2_data) ? SEL_BR : SEL_PC4;
        default: sel = SEL_PC4;
      endcase
    end
  end

  always_comb begin
    case (sel)
      SEL_ADDR: next_pc = address;
      SEL_RS:   next_pc = Rs;
      SEL_BR:   next_pc = Branch;
      default:  next_pc = cur_pc + 32'd4;
    endcase
  end

  assign NextInstrSel = sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      cur_pc     <= RESET_PC;
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_aluop   <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_illegal <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          cur_pc     <= RESET_PC;
          ex_valid   <= 1'b0;
          ex_illegal <= 1'b0;
        end
        RUN: begin
          // Undefined opcodes travel down the pipe as a NOP with the illegal flag.
          ex_valid   <= 1'b1;
          ex_illegal <= ~d_legal;
          ex_opcode  <= d_legal ? d_op : OP_NOP;
          ex_aluop   <= d_rtype ? d_alu : 3'b000;
          ex_rd      <= d_writes ? d_rd : 5'd0;
          ex_a       <= rs1_data;
          ex_b       <= d_rtype ? rs2_data : d_imm;
          ex_imm     <= d_imm;
          ex_pc      <= cur_pc;
          cur_pc     <= next_pc;
          state      <= (sel != SEL_PC4) ? FLUSH : RUN;
        end
        FLUSH: begin
          ex_valid   <= 1'b0;
          ex_illegal <= 1'b0;
          state      <= RUN;
        end
        default: begin
          state      <= BOOT;
          ex_valid   <= 1'b0;
          ex_illegal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Consumer end of the instruction fetch interface.
- Takes the 32-bit word from the fetch pipeline register and decodes it.
- Drives the fetch next-PC controls: select, jump address, register target, branch target.
- Tracks the PC of the word it is looking at, squashes the wrong-path word after each redirect, and registers decoded fields into the decode/execute pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000: PC the fetch PC register holds after reset; must match the fetch stage.
- W, 32: instruction, data and address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Instruction  in  32  word from the fetch pipeline register.
- rs1_data  in  32  register-file read data for rs1_addr (combinational read).
- rs2_data  in  32  register-file read data for rs2_addr.
- rs1_addr  out  5  register-file read address 1.
- rs2_addr  out  5  register-file read address 2.
- NextInstrSel  out  2  fetch mux select: 00 pc+4, 01 address, 10 Rs, 11 Branch.
- address  out  32  jump target.
- Rs  out  32  register jump target.
- Branch  out  32  branch target.
- ex_valid  out  1  execute-stage word valid.
- ex_opcode  out  5  decoded opcode.
- ex_aluop  out  3  decoded ALU op.
- ex_rd  out  5  destination register.
- ex_a  out  32  operand A.
- ex_b  out  32  operand B.
- ex_imm  out  32  sign-extended immediate.
- ex_pc  out  32  PC of the execute-stage word.
- ex_illegal  out  1  one-cycle pulse for an undefined opcode.

Behaviour:
- Instruction formats:
  - R-type: op[31:27], alu[26:24], rd[23:19], rs1[18:14], rs2[13:9].
  - I-type and branch: op[31:27], rd[26:22], rs1[21:17], imm[15:0].
  - J-type: op[31:27], addr[26:0].
- Operand sources:
  - rs1_addr = rs1 field of the decoded format.
  - rs2_addr = rs2 for R-type; rd field for branches, which compare rs1 against rd.
- Redirect targets (combinational from Instruction and cur_pc):
  - address = {5'b0, addr}.
  - Rs = rs1_data.
  - Branch = cur_pc + 4 + (sext(imm) << 2), mod 2^32 with no overflow flag.
- FSM states: BOOT, RUN, FLUSH.
- Reset (rst low, asynchronous):
  - state = BOOT, cur_pc = RESET_PC.
  - All ex_* outputs = 0.
- BOOT:
  - The fetch register holds a bubble.
  - NextInstrSel = 00, nothing is issued.
  - Next state RUN with cur_pc = RESET_PC.
- RUN: decode Instruction.
  - JMP: sel 01.
  - JR: sel 10.
  - BEQ taken when rs1_data == rs2_data; BNE taken when they differ. Taken → sel 11, not taken → sel 00.
  - Everything else: sel 00.
  - Every word in RUN is issued (ex_valid = 1 next cycle), including redirecting ones.
  - Redirect (sel ≠ 00): next state FLUSH, cur_pc ← selected target.
  - No redirect: cur_pc ← cur_pc + 4, wrapping at 2^32.
- FLUSH:
  - The fetch register holds the wrong-path word at old pc+4. Squash it: ex_valid = 0, NextInstrSel = 00, no illegal pulse.
  - cur_pc holds.
  - Next state RUN.
- Latency:
  - Redirect outputs are combinational in the same cycle.
  - ex_* outputs are registered one cycle after the word is decoded.
  - The first useful word is issued 2 cycles after reset release.
- ex_* contents:
  - ex_a = rs1_data.
  - ex_b = rs2_data for R-type, sext(imm) for I-type.
  - ex_pc = cur_pc.
- Opcode 5'h00 is NOP: issued with ex_valid = 1 and ex_rd = 0.
- Undefined opcode: issued as NOP with ex_illegal = 1 for one cycle; no redirect.
- Back-to-back redirects cannot occur, because FLUSH always intervenes.
- Reset asserted mid-operation: immediate return to BOOT, ex_valid = 0 asynchronously, any pending FLUSH is discarded.

Decomposition:
- Shared package isa_pkg:
  - Opcode constants: OP_NOP = 5'h00, OP_ADD_R = 5'h01, OP_ADDI = 5'h02, OP_JMP = 5'h10, OP_JR = 5'h11, OP_BEQ = 5'h12, OP_BNE = 5'h13.
  - Next-PC select enum: SEL_PC4, SEL_ADDR, SEL_RS, SEL_BR.
  - Field-position localparams.
  - fsm_state_t enum.
- One sub-module, instr_field_decode: purely combinational field split, sign extension and format classification; reusable by the later hazard unit.

Test Plan:
- Reset release with a stream of ADDI words at PC 0, 4, 8 → ex_valid rises at cycle 2; ex_pc = 0, 4, 8 on successive cycles; NextInstrSel = 00 throughout.
- JMP addr = 27'h40 at PC 8 → same cycle: NextInstrSel = 01, address = 32'h40. Next cycle: ex_valid = 0 (FLUSH). Following cycle: ex_pc = 32'h40.
- BEQ, imm = 16'hFFFE, at PC 32'h20 with rs1_data == rs2_data = 5 → Branch = 32'h1C, sel 11, one squashed cycle. Repeat with rs2_data = 6 → sel 00, no flush.
- JR with rs1_data = 32'h100 → sel 10, Rs = 32'h100, next ex_pc = 32'h100. BNE at PC 32'hFFFF_FFFC, not taken → cur_pc wraps to 0.
- Opcode 5'h1F → ex_illegal pulses one cycle, ex_valid = 1, sel 00. Same opcode arriving during FLUSH → no pulse.
- rst driven low mid-FLUSH (asynchronous, between edges) → ex_valid = 0 immediately. After release: BOOT, then ex_pc = RESET_PC.
